// File: rtl/matmul_pkg.sv
`default_nettype none
// matmul_pkg: shared dimensions and FSM state type for the part-4 matrix-vector blocks.
package matmul_pkg;

   localparam int N      = 8;
   localparam int DATA_W = 14;
   localparam int ACC_W  = 28;
   localparam int X_AW   = $clog2(N);
   localparam int W_AW   = 2 * X_AW;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LOAD_X  = 3'd1,
      LOAD_W  = 3'd2,
      COMPUTE = 3'd3,
      DRAIN   = 3'd4
   } state_t;

endpackage
`default_nettype wire

// File: rtl/matmul_ctrl_part4.sv
`default_nettype none
// matmul_ctrl_part4: load/compute sequencer for the 8x8 matrix-vector datapath.
// Define MATMUL_CTRL_WREUSE_EN to add start_load_w (0 = reuse the stored W, skip LOAD_W).
module matmul_ctrl_part4 #(
   parameter int N = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
`ifdef MATMUL_CTRL_WREUSE_EN
   input  logic                          start_load_w,
`endif
   input  logic [matmul_pkg::DATA_W-1:0] in_data,
   input  logic                          in_valid,
   output logic                          in_ready,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic                          busy,
   output logic                          done,
   output logic [matmul_pkg::DATA_W-1:0] input_data,
   output logic [$clog2(N)-1:0]          addr_x,
   output logic                          wr_en_x,
   output logic [2*$clog2(N)-1:0]        addr_w,
   output logic                          wr_en_w,
   output logic                          clear_acc,
   output logic                          en_acc,
   output logic                          en_pipe
);
   import matmul_pkg::*;

   localparam int XA = $clog2(N);
   localparam int WA = 2 * XA;
   localparam logic [WA-1:0] LAST_X   = WA'(N - 1);
   localparam logic [WA-1:0] LAST_W   = WA'(N * N - 1);
   localparam logic [XA-1:0] LAST_ROW = XA'(N - 1);

   state_t          state, state_nxt;
   logic [WA-1:0]   cnt, cnt_nxt;
   logic [XA-1:0]   out_cnt, out_cnt_nxt;
   logic            load_w, load_w_nxt, load_w_sel;
   logic            v1, v2;
   logic            done_nxt;
   logic            advance, issue, hs_out;

`ifdef MATMUL_CTRL_WREUSE_EN
   assign load_w_sel = start_load_w;
`else
   assign load_w_sel = 1'b1;
`endif

   // Only an unconsumed result blocks the pipeline; everything behind it freezes.
   assign advance    = !(out_valid && !out_ready);
   assign hs_out     = out_valid && out_ready;
   assign busy       = (state != IDLE);
   assign input_data = in_data;
   assign en_pipe    = advance && ((state == COMPUTE) || (state == DRAIN));
   assign en_acc     = advance && v2;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         out_cnt   <= '0;
         load_w    <= 1'b1;
         v1        <= 1'b0;
         v2        <= 1'b0;
         out_valid <= 1'b0;
         done      <= 1'b0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         out_cnt <= out_cnt_nxt;
         load_w  <= load_w_nxt;
         done    <= done_nxt;
         if (advance) begin
            v1        <= issue;
            v2        <= v1;
            out_valid <= v2;
         end
      end
   end

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      out_cnt_nxt = hs_out ? out_cnt + XA'(1) : out_cnt;
      load_w_nxt  = load_w;
      done_nxt    = 1'b0;
      in_ready    = 1'b0;
      wr_en_x     = 1'b0;
      wr_en_w     = 1'b0;
      addr_x      = '0;
      addr_w      = '0;
      clear_acc   = rst;
      issue       = 1'b0;

      unique case (state)
         IDLE: begin
            if (start) begin
               state_nxt   = LOAD_X;
               cnt_nxt     = '0;
               out_cnt_nxt = '0;
               load_w_nxt  = load_w_sel;
               clear_acc   = 1'b1;
            end
         end
         LOAD_X: begin
            in_ready = 1'b1;
            wr_en_x  = in_valid;
            addr_x   = cnt[XA-1:0];
            if (in_valid) begin
               if (cnt == LAST_X) begin
                  cnt_nxt   = '0;
                  state_nxt = load_w ? LOAD_W : COMPUTE;
               end else begin
                  cnt_nxt = cnt + WA'(1);
               end
            end
         end
         LOAD_W: begin
            in_ready = 1'b1;
            wr_en_w  = in_valid;
            addr_w   = cnt;
            if (in_valid) begin
               if (cnt == LAST_W) begin
                  cnt_nxt   = '0;
                  state_nxt = COMPUTE;
               end else begin
                  cnt_nxt = cnt + WA'(1);
               end
            end
         end
         COMPUTE: begin
            // The row index is held in the low bits of the load counter.
            addr_w = {cnt[XA-1:0], {XA{1'b0}}};
            issue  = advance;
            if (advance) begin
               if (cnt[XA-1:0] == LAST_ROW) begin
                  cnt_nxt   = '0;
                  state_nxt = DRAIN;
               end else begin
                  cnt_nxt = cnt + WA'(1);
               end
            end
         end
         DRAIN: begin
            if (hs_out && (out_cnt == LAST_ROW)) begin
               state_nxt = IDLE;
               done_nxt  = 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_matmul_ctrl_part4.sv
`default_nettype none
// tb_matmul_ctrl_part4: directed jobs through the sequencer feeding a behavioural
// model of the 3-stage saturating datapath.
module tb_matmul_ctrl_part4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
`ifdef MATMUL_CTRL_WREUSE_EN
   logic        start_load_w = 1'b1;
`endif
   logic [13:0] in_data = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic        busy, done;
   logic [13:0] input_data;
   logic [2:0]  addr_x;
   logic        wr_en_x;
   logic [5:0]  addr_w;
   logic        wr_en_w, clear_acc, en_acc, en_pipe;

   always #5 clk = ~clk;

   matmul_ctrl_part4 #(.N(8)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
`ifdef MATMUL_CTRL_WREUSE_EN
      .start_load_w (start_load_w),
`endif
      .in_data      (in_data),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .busy         (busy),
      .done         (done),
      .input_data   (input_data),
      .addr_x       (addr_x),
      .wr_en_x      (wr_en_x),
      .addr_w       (addr_w),
      .wr_en_w      (wr_en_w),
      .clear_acc    (clear_acc),
      .en_acc       (en_acc),
      .en_pipe      (en_pipe)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   // Behavioural datapath: sync-write memories, comb read, saturating row sum.
   logic signed [13:0] xm [8];
   logic signed [13:0] wm [64];
   logic signed [27:0] s1, s2, out_data;

   always @(posedge clk) begin : dp
      longint acc;
      acc = 0;
      for (int c = 0; c < 8; c++)
         acc += longint'(xm[c]) * longint'(wm[int'(addr_w[5:3]) * 8 + c]);
      if (acc > 134217727) acc = 134217727;
      else if (acc < -134217728) acc = -134217728;
      if (wr_en_x) xm[addr_x] <= input_data;
      if (wr_en_w) wm[addr_w] <= input_data;
      if (en_pipe) begin
         s1 <= 28'(acc);
         s2 <= s1;
      end
      if (clear_acc) out_data <= '0;
      else if (en_acc) out_data <= s2;
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic signed [27:0] got_q [$];
   int                 cyc_q [$];
   int                 nx, nw;
   bit                 stall_arm = 1'b0;
   bit                 stall_used = 1'b0;
   int                 stall_left = 0;
   logic signed [27:0] held;

   // Backpressure injection first, then result capture with the updated out_ready.
   always @(negedge clk) begin
      if (stall_left > 0) begin
         check("stall_en_pipe", en_pipe, 0);
         check("stall_en_acc", en_acc, 0);
         check("stall_out_valid", out_valid, 1);
         check("stall_data", out_data, held);
         stall_left = stall_left - 1;
         if (stall_left == 0) out_ready = 1'b1;
      end else if (stall_arm && !stall_used && !rst && out_valid && out_ready) begin
         stall_used = 1'b1;
         out_ready  = 1'b0;
         held       = out_data;
         stall_left = 5;
      end
      if (!rst && out_valid && out_ready) begin
         got_q.push_back(out_data);
         cyc_q.push_back(cyc);
      end
      if (wr_en_x) nx++;
      if (wr_en_w) nw++;
   end

   logic signed [13:0] xv [8];
   logic signed [13:0] wv [64];
   int                 ev [8];
   int                 st_cyc;

   task automatic start_job();
      @(negedge clk);
      start  = 1'b1;
      st_cyc = cyc;
      nx = 0;
      nw = 0;
      got_q.delete();
      cyc_q.delete();
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send(input logic [13:0] d);
      int t = 0;
      in_valid = 1'b1;
      in_data  = d;
      while (!in_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) check("in_ready_timeout", 0, 1);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic feed(input bit gaps, input bit with_w);
      for (int i = 0; i < 8; i++) begin
         if (gaps && (i % 3 == 2)) @(negedge clk);
         send(xv[i]);
      end
      if (with_w) begin
         for (int i = 0; i < 64; i++) begin
            if (gaps && (i % 5 == 4)) @(negedge clk);
            send(wv[i]);
         end
      end
   endtask

   task automatic finish_job(input string tag, input int exp_w);
      int t = 0;
      while (!done && t < 300) begin
         @(negedge clk);
         t++;
      end
      check({tag, "_done"}, done, 1);
      check({tag, "_busy_at_done"}, busy, 0);
      check({tag, "_count"}, got_q.size(), 8);
      for (int i = 0; i < 8 && i < got_q.size(); i++)
         check($sformatf("%s_res%0d", tag, i), got_q[i], ev[i]);
      check({tag, "_nx"}, nx, 8);
      check({tag, "_nw"}, nw, exp_w);
      if (got_q.size() == 8) check({tag, "_done_timing"}, cyc - cyc_q[7], 1);
      @(negedge clk);
      check({tag, "_done_pulse"}, done, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int t;
      repeat (3) @(negedge clk);
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_wr_en_x", wr_en_x, 0);
      check("rst_wr_en_w", wr_en_w, 0);
      check("rst_en_pipe", en_pipe, 0);
      check("rst_en_acc", en_acc, 0);
      check("rst_addr_x", addr_x, 0);
      check("rst_addr_w", addr_w, 0);
      check("rst_clear_acc", clear_acc, 1);
      rst = 1'b0;

      // Input words offered while idle are refused.
      in_valid = 1'b1;
      @(negedge clk);
      check("idle_in_ready", in_ready, 0);
      check("idle_wr_en_x", wr_en_x, 0);
      check("idle_clear_acc", clear_acc, 0);
      in_valid = 1'b0;

      // X = 1..8, W = identity
      for (int i = 0; i < 8; i++) begin
         xv[i] = 14'(i + 1);
         ev[i] = i + 1;
      end
      for (int i = 0; i < 64; i++) wv[i] = (i / 8 == i % 8) ? 14'sd1 : 14'sd0;
      start_job();
      feed(1'b0, 1'b1);
      finish_job("ident", 64);
      if (cyc_q.size() == 8) begin
         check("ident_latency", cyc_q[7] - st_cyc, 83);
         check("ident_back_to_back", cyc_q[7] - cyc_q[0], 7);
      end

`ifdef MATMUL_CTRL_WREUSE_EN
      // Reuse identity W with a new X = 8..1.
      for (int i = 0; i < 8; i++) begin
         xv[i] = 14'(8 - i);
         ev[i] = 8 - i;
      end
      start_load_w = 1'b0;
      start_job();
      start_load_w = 1'b1;
      feed(1'b0, 1'b0);
      finish_job("reuse", 0);
`endif

      // X all 3, W all 2, with gaps in in_valid
      for (int i = 0; i < 8; i++) begin
         xv[i] = 14'sd3;
         ev[i] = 48;
      end
      for (int i = 0; i < 64; i++) wv[i] = 14'sd2;
      start_job();
      feed(1'b1, 1'b1);
      finish_job("gap", 64);

      // Positive saturation
      for (int i = 0; i < 8; i++) begin
         xv[i] = 14'sd8191;
         ev[i] = 134217727;
      end
      for (int i = 0; i < 64; i++) wv[i] = 14'sd8191;
      start_job();
      feed(1'b0, 1'b1);
      finish_job("satpos", 64);

      // Negative saturation with 5 cycles of backpressure on the first result
      for (int i = 0; i < 8; i++) begin
         xv[i] = -14'sd8192;
         ev[i] = -134217728;
      end
      stall_arm = 1'b1;
      start_job();
      feed(1'b0, 1'b1);
      finish_job("satneg_stall", 64);
      stall_arm = 1'b0;
      check("stall_happened", stall_used, 1);

      // Reset while row 4 is being issued, then a fresh job.
      for (int i = 0; i < 8; i++) xv[i] = 14'(i + 1);
      for (int i = 0; i < 64; i++) wv[i] = (i / 8 == i % 8) ? 14'sd1 : 14'sd0;
      start_job();
      feed(1'b0, 1'b1);
      t = 0;
      while (!(busy && !in_ready && en_pipe && addr_w == 6'd32) && t < 50) begin
         @(negedge clk);
         t++;
      end
      check("abort_row4_found", addr_w, 32);
      rst = 1'b1;
      @(negedge clk);
      check("abort_busy", busy, 0);
      check("abort_out_valid", out_valid, 0);
      check("abort_clear_acc", clear_acc, 1);
      check("abort_en_pipe", en_pipe, 0);
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         xv[i] = 14'sd3;
         ev[i] = 48;
      end
      for (int i = 0; i < 64; i++) wv[i] = 14'sd2;
      start_job();
      feed(1'b0, 1'b1);
      finish_job("after_rst", 64);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
